// File: rtl/fixed2float_pkg.sv
// Shared constants and types for the Q17.26 -> binary16 converter.
package fixed2float_pkg;

  // Input fixed-point format
  localparam int FIXED_W  = 44;
  localparam int FRAC_W   = 26;

  // binary16 field layout
  localparam int EXP_BIAS = 15;
  localparam int EXP_W    = 5;
  localparam int MANT_W   = 10;
  localparam int HALF_W   = 1 + EXP_W + MANT_W;

  // Largest biased exponent that is still finite
  localparam int EXP_MAX  = 30;

  // Leading-one positions that map onto normal exponents 1..30
  localparam int MIN_NORM_POS = FRAC_W - EXP_BIAS + 1;        // 12
  localparam int MAX_NORM_POS = FRAC_W - EXP_BIAS + EXP_MAX;  // 41

  // Priority encoder geometry: bit 43 of the magnitude is only ever set
  // for -2^43, which saturates anyway, so the encoder spans bits 42..0.
  localparam int LOD_W = FIXED_W - 1;
  localparam int IDX_W = 6;

  // Saturation pattern (largest finite magnitude)
  localparam logic [EXP_W-1:0]  SAT_EXP  = 5'h1E;
  localparam logic [MANT_W-1:0] SAT_MANT = 10'h3FF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } half_t;

  // Assemble a half-precision word from its fields.
  function automatic half_t pack_half(input logic              sign,
                                      input logic [EXP_W-1:0]  exp,
                                      input logic [MANT_W-1:0] mant);
    half_t h;
    h.sign = sign;
    h.exp  = exp;
    h.mant = mant;
    return h;
  endfunction

endpackage

// File: rtl/fixed2float_conv_lead_one_det43.sv
// Combinational 43-bit priority encoder: index of the highest set bit
// plus an all-zero flag. Index is 0 when the vector is zero.
module lead_one_det43
  import fixed2float_pkg::*;
(
  input  logic [LOD_W-1:0] i_vec,
  output logic [IDX_W-1:0] o_index,
  output logic             o_zero
);

  assign o_zero = ~|i_vec;

  // Scan upward so the highest set bit is the last one to claim the index.
  always_comb begin
    o_index = '0;
    for (int i = 0; i < LOD_W; i++) begin
      o_index = i_vec[i] ? IDX_W'(i) : o_index;
    end
  end

endmodule

// File: rtl/fixed2float_conv.sv
// Two-stage pipelined converter from signed Q17.26 fixed point to
// IEEE-754 binary16. Truncates toward zero, saturates to the largest
// finite value on overflow and flushes small magnitudes to +0.
module fixed2float_conv
  import fixed2float_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [FIXED_W-1:0] fixed_in,
  output logic [HALF_W-1:0]  float_out
);

  // ---------------- Stage 1: sign and magnitude ----------------
  logic               w_sign;
  logic [FIXED_W-1:0] w_mag;
  logic               r_sign;
  logic [FIXED_W-1:0] r_mag;

  assign w_sign = fixed_in[FIXED_W-1];
  // 44-bit negate: -2^43 becomes 2^43 with bit 43 set, caught as overflow.
  assign w_mag  = w_sign ? (~fixed_in + FIXED_W'(1)) : fixed_in;

  // Capture sign and absolute value of the incoming sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sign <= 1'b0;
      r_mag  <= '0;
    end else begin
      r_sign <= w_sign;
      r_mag  <= w_mag;
    end
  end

  // ---------------- Stage 2: normalise and pack ----------------
  logic [IDX_W-1:0]  w_lod_idx;
  logic              w_lod_zero;
  logic [LOD_W-1:0]  w_norm;
  logic [IDX_W-1:0]  w_exp_full;
  logic [MANT_W-1:0] w_mant;
  half_t             w_half;
  half_t             r_float;

  lead_one_det43 u_lod (
    .i_vec   (r_mag[LOD_W-1:0]),
    .o_index (w_lod_idx),
    .o_zero  (w_lod_zero)
  );

  // Left-justify so the leading one lands on bit 42; the ten bits below it
  // are the stored mantissa and everything lower is dropped.
  assign w_norm     = r_mag[LOD_W-1:0] << (IDX_W'(LOD_W - 1) - w_lod_idx);
  assign w_mant     = w_norm[LOD_W-2 -: MANT_W];
  assign w_exp_full = w_lod_idx - IDX_W'(FRAC_W - EXP_BIAS);

  // Choose between saturation, flush-to-zero and the normal encoding.
  always_comb begin
    w_half = '0;
    if (r_mag[FIXED_W-1] || (w_lod_idx > IDX_W'(MAX_NORM_POS))) begin
      w_half = pack_half(r_sign, SAT_EXP, SAT_MANT);
    end else if (w_lod_zero || (w_lod_idx < IDX_W'(MIN_NORM_POS))) begin
      w_half = '0;
    end else begin
      w_half = pack_half(r_sign, w_exp_full[EXP_W-1:0], w_mant);
    end
  end

  // Register the packed half-precision result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_float <= '0;
    end else begin
      r_float <= w_half;
    end
  end

  assign float_out = r_float;

endmodule

// File: tb/tb_fixed2float_conv.sv
// Scoreboard bench for fixed2float_conv: the driver pushes expected
// results, a monitor pops and compares whenever a tracked sample reaches
// the output two clock edges after being sampled.
module tb_fixed2float_conv;

  typedef struct {
    logic [43:0] x;
    logic [15:0] e;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [43:0] fixed_in = 44'h0;
  logic [15:0] float_out;

  int n_tests = 0;
  int n_fail  = 0;

  sb_t  exp_q[$];
  logic drv_valid = 1'b0;
  logic vld_d1, vld_d2;

  always #5 clk = ~clk;

  fixed2float_conv dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .fixed_in  (fixed_in),
    .float_out (float_out)
  );

  // Track which output cycles carry a scoreboarded sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_d1 <= 1'b0;
      vld_d2 <= 1'b0;
    end else begin
      vld_d1 <= drv_valid;
      vld_d2 <= vld_d1;
    end
  end

  // Monitor: compare the DUT output against the oldest expectation.
  always @(negedge clk) begin
    sb_t t;
    if (vld_d2) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow got=%h", float_out);
      end else begin
        t = exp_q.pop_front();
        if (float_out !== t.e) begin
          n_fail++;
          $display("FAIL scoreboard in=%h got=%h expected=%h", t.x, float_out, t.e);
        end
      end
    end
  end

  // Independent reference: walk bits to find the leading one, then shift.
  function automatic logic [15:0] model(input logic [43:0] x);
    logic        s;
    logic [43:0] m;
    logic [43:0] t;
    logic [4:0]  e;
    int          p;
    s = x[43];
    m = s ? (44'd0 - x) : x;
    p = -1;
    for (int i = 0; i < 44; i++) begin
      if (m[i]) p = i;
    end
    if (p < 12) return 16'h0000;
    if (p >= 42) return {s, 5'h1E, 10'h3FF};
    e = 5'(p - 11);
    t = m >> (p - 10);
    return {s, e, t[9:0]};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, act, req);
    end
  endtask

  task automatic drive(input logic [43:0] x, input logic [15:0] e);
    sb_t t;
    @(negedge clk);
    fixed_in  = x;
    drv_valid = 1'b1;
    t.x = x;
    t.e = e;
    exp_q.push_back(t);
  endtask

  task automatic idle();
    @(negedge clk);
    drv_valid = 1'b0;
  endtask

  logic [43:0] vec_x [0:17];
  logic [15:0] vec_e [0:17];

  initial begin
    logic [63:0]        r;
    logic signed [43:0] xs;
    int                 waited;

    // Hand-computed directed vectors
    vec_x[0]  = 44'h000_0400_0000; vec_e[0]  = 16'h3C00; // +1.0
    vec_x[1]  = 44'hFFF_FC00_0000; vec_e[1]  = 16'hBC00; // -1.0
    vec_x[2]  = 44'h000_0600_0000; vec_e[2]  = 16'h3E00; // +1.5
    vec_x[3]  = 44'hFFF_FA00_0000; vec_e[3]  = 16'hBE00; // -1.5
    vec_x[4]  = 44'h000_0400_FFFF; vec_e[4]  = 16'h3C00; // bits below m[16] dropped
    vec_x[5]  = 44'h000_0400_4000; vec_e[5]  = 16'h3C00; // bit 14 is below mantissa LSB
    vec_x[6]  = 44'h000_0401_0000; vec_e[6]  = 16'h3C01; // mantissa LSB (bit 16)
    vec_x[7]  = 44'h200_0000_0000; vec_e[7]  = 16'h7800; // p=41
    vec_x[8]  = 44'h3FF_FFFF_FFFF; vec_e[8]  = 16'h7BFF; // p=41, all mant ones
    vec_x[9]  = 44'h400_0000_0000; vec_e[9]  = 16'h7BFF; // p=42 saturates
    vec_x[10] = 44'h7FF_FFFF_FFFF; vec_e[10] = 16'h7BFF; // max positive
    vec_x[11] = 44'h800_0000_0000; vec_e[11] = 16'hFBFF; // -2^43
    vec_x[12] = 44'h000_0000_1000; vec_e[12] = 16'h0400; // p=12
    vec_x[13] = 44'hFFF_FFFF_F000; vec_e[13] = 16'h8400; // -(p=12)
    vec_x[14] = 44'h000_0000_0800; vec_e[14] = 16'h0000; // p=11 flush
    vec_x[15] = 44'h000_0000_0000; vec_e[15] = 16'h0000; // zero
    vec_x[16] = 44'hFFF_FFFF_FFFF; vec_e[16] = 16'h0000; // -1 LSB, sign dropped
    vec_x[17] = 44'hFFF_FFFF_F800; vec_e[17] = 16'h0000; // -(p=11), sign dropped

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", float_out, 16'h0000);
    reset_n = 1'b1;

    // Latency: output must still be zero one edge after sampling +1.0
    drive(44'h000_0400_0000, 16'h3C00);
    @(negedge clk);
    drv_valid = 1'b0;
    check("latency_not_early", float_out, 16'h0000);
    repeat (3) idle();

    // Directed vectors back to back
    for (int i = 0; i < 18; i++) drive(vec_x[i], vec_e[i]);

    // Random samples across all magnitudes against the reference model
    for (int i = 0; i < 3000; i++) begin
      r  = {$urandom, $urandom};
      xs = r[43:0];
      xs = xs >>> $urandom_range(0, 43);
      drive(xs, model(xs));
    end

    // Reset mid-stream: asynchronous clear, in-flight samples discarded
    drive(44'h000_0600_0000, 16'h3E00);
    drive(44'hFFF_FC00_0000, 16'hBC00);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_clear", float_out, 16'h0000);
    exp_q.delete();
    drv_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset_hold", float_out, 16'h0000);
    end

    // Release and issue a sample on the same negedge
    @(negedge clk);
    reset_n = 1'b1;
    fixed_in = 44'h000_0400_0000;
    drv_valid = 1'b1;
    begin
      sb_t t;
      t.x = 44'h000_0400_0000;
      t.e = 16'h3C00;
      exp_q.push_back(t);
    end
    @(negedge clk);
    drv_valid = 1'b0;
    check("post_reset_hold", float_out, 16'h0000);
    drive(44'hFFF_FA00_0000, 16'hBE00);
    idle();

    // Drain the scoreboard with a bounded wait
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout pending=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
